policy_deck_ctrl: RTL and testbench

POLICY_DECK_CTRL -- requirements
Module: policy_deck_ctrl

---
 rtl/snpu_pkg.sv | 36 +++
 rtl/snpu_lfsr.sv | 27 ++
 rtl/policy_deck_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_policy_deck_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snpu_pkg.sv
// Shared types and constants for the policy deck controller.
// Optional PEEK support is selected in the top with SNPU_PEEK_EN.
package snpu_pkg;

  typedef enum logic [2:0] {
    OpNop     = 3'd0,
    OpNewGame = 3'd1,
    OpDraw3   = 3'd2,
    OpDiscard = 3'd3,
    OpEnact   = 3'd4,
    OpShuffle = 3'd5,
    OpPeek    = 3'd6,
    OpRsvd    = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMerge,
    StShuf,
    StResp
  } state_e;

  localparam int unsigned DeckNDefault = 17;
  localparam int unsigned LibNDefault  = 6;

  localparam logic [2:0] LibWin = 3'd5;
  localparam logic [2:0] FasWin = 3'd6;

  localparam logic [7:0] LfsrSeedDefault = 8'h01;

  // x^8 + x^6 + x^5 + x^4 + 1, new bit enters at bit0
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/snpu_lfsr.sv
// Free-running 8-bit Fibonacci LFSR with synchronous seed load.
// A zero seed is replaced by the default seed so the register never locks up.
module snpu_lfsr
  import snpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] seed,
  output logic [7:0] state
);

  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LfsrSeedDefault;
    end else if (load) begin
      lfsr_q <= (seed == 8'h00) ? LfsrSeedDefault : seed;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/policy_deck_ctrl.sv
// Policy card deck controller: draw/discard/enact with LFSR-driven Fisher-Yates reshuffle.
// Define SNPU_PEEK_EN to enable the PEEK opcode; otherwise it is rejected.
module policy_deck_ctrl
  import snpu_pkg::*;
#(
  parameter int unsigned DECK_N = DeckNDefault,
  parameter int unsigned LIB_N  = LibNDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [1:0]        cmd_idx,
  input  logic [7:0]        seed,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [2:0]        hand,
  output logic [1:0]        hand_n,
  output logic [DECK_N-1:0] stack,
  output logic [4:0]        stack_n,
  output logic [4:0]        discard_n,
  output logic [2:0]        lib_board,
  output logic [2:0]        fas_board,
  output logic              game_over
);

  localparam logic [DECK_N-1:0] DeckInit  = {{(DECK_N - LIB_N){1'b0}}, {LIB_N{1'b1}}};
  localparam logic [4:0]        DeckCount = 5'(DECK_N);

  state_e            state_q, state_d;
  logic [DECK_N-1:0] stack_q, stack_d;
  logic [4:0]        stack_n_q, stack_n_d;
  logic [DECK_N-1:0] disc_q, disc_d;
  logic [4:0]        disc_n_q, disc_n_d;
  logic [2:0]        hand_q, hand_d;
  logic [1:0]        hand_n_q, hand_n_d;
  logic [2:0]        lib_q, lib_d;
  logic [2:0]        fas_q, fas_d;
  logic              over_q, over_d;
  logic              err_q, err_d;
  logic [4:0]        idx_q, idx_d;

  logic       lfsr_load;
  logic [7:0] lfsr;
  logic [4:0] rnd;
  logic       unused_lfsr_hi;
  logic       disc_bit;
  logic       enact_bit;
  logic [4:0] merge_n;
  op_e        op;

  snpu_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .seed  (seed),
    .state (lfsr)
  );

  assign rnd            = lfsr[4:0];
  assign unused_lfsr_hi = ^lfsr[7:5];
  assign op             = op_e'(cmd_op);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      stack_q   <= DeckInit;
      stack_n_q <= DeckCount;
      disc_q    <= '0;
      disc_n_q  <= '0;
      hand_q    <= '0;
      hand_n_q  <= '0;
      lib_q     <= '0;
      fas_q     <= '0;
      over_q    <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      stack_q   <= stack_d;
      stack_n_q <= stack_n_d;
      disc_q    <= disc_d;
      disc_n_q  <= disc_n_d;
      hand_q    <= hand_d;
      hand_n_q  <= hand_n_d;
      lib_q     <= lib_d;
      fas_q     <= fas_d;
      over_q    <= over_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stack_d   = stack_q;
    stack_n_d = stack_n_q;
    disc_d    = disc_q;
    disc_n_d  = disc_n_q;
    hand_d    = hand_q;
    hand_n_d  = hand_n_q;
    lib_d     = lib_q;
    fas_d     = fas_q;
    over_d    = over_q;
    err_d     = err_q;
    idx_d     = idx_q;
    lfsr_load = 1'b0;
    disc_bit  = 1'b0;
    enact_bit = 1'b0;
    merge_n   = stack_n_q + disc_n_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          err_d   = 1'b0;
          state_d = StResp;
          unique case (op)
            OpNop: begin
            end
            OpNewGame: begin
              lfsr_load = 1'b1;
              stack_d   = DeckInit;
              stack_n_d = DeckCount;
              disc_d    = '0;
              disc_n_d  = '0;
              hand_d    = '0;
              hand_n_d  = '0;
              lib_d     = '0;
              fas_d     = '0;
              over_d    = 1'b0;
              state_d   = StMerge;
            end
            OpDraw3: begin
              if (over_q || hand_n_q != 2'd0 || stack_n_q < 5'd3) begin
                err_d = 1'b1;
              end else begin
                hand_d    = stack_q[2:0];
                stack_d   = stack_q >> 3;
                stack_n_d = stack_n_q - 5'd3;
                hand_n_d  = 2'd3;
              end
            end
            OpDiscard: begin
              if (over_q || hand_n_q != 2'd3 || cmd_idx == 2'd3) begin
                err_d = 1'b1;
              end else begin
                // Surviving cards keep their relative order in hand[1:0]
                case (cmd_idx)
                  2'd0: begin
                    disc_bit = hand_q[0];
                    hand_d   = {1'b0, hand_q[2:1]};
                  end
                  2'd1: begin
                    disc_bit = hand_q[1];
                    hand_d   = {1'b0, hand_q[2], hand_q[0]};
                  end
                  default: begin
                    disc_bit = hand_q[2];
                    hand_d   = {1'b0, hand_q[1:0]};
                  end
                endcase
                disc_d   = disc_q | ({{(DECK_N - 1){1'b0}}, disc_bit} << disc_n_q);
                disc_n_d = disc_n_q + 5'd1;
                hand_n_d = 2'd2;
              end
            end
            OpEnact: begin
              if (over_q || hand_n_q != 2'd2 || cmd_idx[1]) begin
                err_d = 1'b1;
              end else begin
                enact_bit = cmd_idx[0] ? hand_q[1] : hand_q[0];
                disc_bit  = cmd_idx[0] ? hand_q[0] : hand_q[1];
                disc_d    = disc_q | ({{(DECK_N - 1){1'b0}}, disc_bit} << disc_n_q);
                disc_n_d  = disc_n_q + 5'd1;
                lib_d     = lib_q + {2'b00, enact_bit};
                fas_d     = fas_q + {2'b00, ~enact_bit};
                over_d    = (lib_d == LibWin) || (fas_d == FasWin);
                hand_d    = '0;
                hand_n_d  = '0;
                if (stack_n_q < 5'd3) begin
                  state_d = StMerge;
                end
              end
            end
            OpShuffle: begin
              if (over_q) begin
                err_d = 1'b1;
              end else begin
                state_d = StMerge;
              end
            end
            OpPeek: begin
`ifdef SNPU_PEEK_EN
              if (hand_n_q != 2'd0 || stack_n_q < 5'd3) begin
                err_d = 1'b1;
              end else begin
                hand_d = stack_q[2:0];
              end
`else
              err_d = 1'b1;
`endif
            end
            OpRsvd: begin
              err_d = 1'b1;
            end
          endcase
        end
      end
      StMerge: begin
        stack_d   = stack_q | (disc_q << stack_n_q);
        stack_n_d = merge_n;
        disc_d    = '0;
        disc_n_d  = '0;
        idx_d     = (merge_n == 5'd0) ? 5'd0 : merge_n - 5'd1;
        state_d   = StShuf;
      end
      StShuf: begin
        // Out-of-range draws are retried on the next LFSR value
        if (idx_q == 5'd0) begin
          state_d = StResp;
        end else if (rnd <= idx_q) begin
          stack_d[idx_q] = stack_q[rnd];
          stack_d[rnd]   = stack_q[idx_q];
          idx_d          = idx_q - 5'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
    endcase
  end

  assign cmd_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_err   = rsp_valid & err_q;
  assign hand      = hand_q;
  assign hand_n    = hand_n_q;
  assign stack     = stack_q;
  assign stack_n   = stack_n_q;
  assign discard_n = disc_n_q;
  assign lib_board = lib_q;
  assign fas_board = fas_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_policy_deck_ctrl.sv
// Scoreboard bench for policy_deck_ctrl: queue-based card model, randomized command stream.
module tb_policy_deck_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_idx;
  logic [7:0]  seed;
  logic        rsp_valid;
  logic        rsp_err;
  logic [2:0]  hand;
  logic [1:0]  hand_n;
  logic [16:0] stack;
  logic [4:0]  stack_n;
  logic [4:0]  discard_n;
  logic [2:0]  lib_board;
  logic [2:0]  fas_board;
  logic        game_over;

  always #5 clk = ~clk;

  policy_deck_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_idx   (cmd_idx),
    .seed      (seed),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .hand      (hand),
    .hand_n    (hand_n),
    .stack     (stack),
    .stack_n   (stack_n),
    .discard_n (discard_n),
    .lib_board (lib_board),
    .fas_board (fas_board),
    .game_over (game_over)
  );

  typedef struct packed {
    logic        err;
    logic [16:0] stack;
    logic [4:0]  stack_n;
    logic [4:0]  disc_n;
    logic [2:0]  hand;
    logic [1:0]  hand_n;
    logic [2:0]  lib;
    logic [2:0]  fas;
    logic        over;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: cards as queues, index 0 = top of pile
  bit         m_stack[$];
  bit         m_disc[$];
  logic [2:0] m_hand;
  int         m_hn, m_lib, m_fas;
  bit         m_over;
  logic [7:0] m_lfsr;

  function automatic logic [7:0] step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Model LFSR: advances every clock, reloaded from seed on an accepted NEW_GAME
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'h01;
    else if (cmd_valid && cmd_ready && cmd_op == 3'd1) m_lfsr <= (seed == 8'h00) ? 8'h01 : seed;
    else m_lfsr <= step(m_lfsr);
  end

  task automatic model_reset();
    m_stack.delete();
    m_disc.delete();
    for (int k = 0; k < 17; k++) m_stack.push_back(k < 6);
    m_hand = 3'b000;
    m_hn   = 0;
    m_lib  = 0;
    m_fas  = 0;
    m_over = 1'b0;
  endtask

  // lv: LFSR value during the merge cycle; each shuffle cycle sees the next value
  task automatic model_shuffle(input logic [7:0] lv);
    int         i, r, guard;
    logic [7:0] l;
    bit         t;
    while (m_disc.size() > 0) m_stack.push_back(m_disc.pop_front());
    i     = m_stack.size() - 1;
    l     = lv;
    guard = 0;
    while (i > 0 && guard < 100000) begin
      l = step(l);
      r = int'(l[4:0]);
      if (r <= i) begin
        t          = m_stack[i];
        m_stack[i] = m_stack[r];
        m_stack[r] = t;
        i--;
      end
      guard++;
    end
  endtask

  function automatic rsp_t snap(input bit err);
    rsp_t r;
    r     = '0;
    r.err = err;
    foreach (m_stack[k]) r.stack[k] = m_stack[k];
    r.stack_n = 5'(m_stack.size());
    r.disc_n  = 5'(m_disc.size());
    r.hand    = m_hand;
    r.hand_n  = 2'(m_hn);
    r.lib     = 3'(m_lib);
    r.fas     = 3'(m_fas);
    r.over    = m_over;
    return r;
  endfunction

  task automatic model_cmd(input int op, input int idx, input logic [7:0] lv, output rsp_t r);
    bit err, shuf, card, other;
    bit keep[$];
    err  = 1'b0;
    shuf = 1'b0;
    case (op)
      0: ;
      1: begin
        model_reset();
        shuf = 1'b1;
      end
      2: begin
        if (m_over || m_hn != 0 || m_stack.size() < 3) err = 1'b1;
        else begin
          for (int k = 0; k < 3; k++) m_hand[k] = m_stack.pop_front();
          m_hn = 3;
        end
      end
      3: begin
        if (m_over || m_hn != 3 || idx > 2) err = 1'b1;
        else begin
          m_disc.push_back(m_hand[idx]);
          for (int k = 0; k < 3; k++) if (k != idx) keep.push_back(m_hand[k]);
          m_hand = {1'b0, keep[1], keep[0]};
          m_hn   = 2;
        end
      end
      4: begin
        if (m_over || m_hn != 2 || idx > 1) err = 1'b1;
        else begin
          card  = m_hand[idx];
          other = m_hand[1-idx];
          if (card) m_lib++;
          else m_fas++;
          m_disc.push_back(other);
          m_hand = 3'b000;
          m_hn   = 0;
          m_over = (m_lib >= 5) || (m_fas >= 6);
          if (m_stack.size() < 3) shuf = 1'b1;
        end
      end
      5: begin
        if (m_over) err = 1'b1;
        else shuf = 1'b1;
      end
      6: begin
`ifdef SNPU_PEEK_EN
        if (m_hn != 0 || m_stack.size() < 3) err = 1'b1;
        else for (int k = 0; k < 3; k++) m_hand[k] = m_stack[k];
`else
        err = 1'b1;
`endif
      end
      default: err = 1'b1;
    endcase
    if (shuf) model_shuffle(lv);
    r = snap(err);
  endtask

  task automatic wait_ready(output bit ok);
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    ok = cmd_ready;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, t);
    end
  endtask

  task automatic issue(input int op, input int idx, input logic [7:0] sd);
    rsp_t r;
    bit   ok;
    wait_ready(ok);
    if (!ok) return;
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_idx   = 2'(idx);
    seed      = sd;
    @(posedge clk);
    #1;
    model_cmd(op, idx, m_lfsr, r);
    exp_q.push_back(r);
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset(input string name);
    logic [41:0] act, req;
    act = {stack, stack_n, discard_n, hand, hand_n, lib_board, fas_board, game_over,
           cmd_ready, rsp_valid, rsp_err};
    req = {17'h0003F, 5'd17, 5'd0, 3'd0, 2'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got stack=%h sn=%0d dn=%0d hand=%b hn=%0d lib=%0d fas=%0d go=%0b rdy=%0b rv=%0b re=%0b, required state %h",
               name, stack, stack_n, discard_n, hand, hand_n, lib_board, fas_board, game_over,
               cmd_ready, rsp_valid, rsp_err, req);
    end
  endtask

  // Monitor: every response pulse is checked against the oldest expectation
  rsp_t mon_a, mon_e;
  int   mon_sum;
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      mon_a = '{err: rsp_err, stack: stack, stack_n: stack_n, disc_n: discard_n, hand: hand,
                hand_n: hand_n, lib: lib_board, fas: fas_board, over: game_over};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rsp_unexpected: rsp_valid=1 with no command outstanding, required 0");
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a !== mon_e) begin
          n_err++;
          $display("FAIL rsp: got err=%0b stack=%h sn=%0d dn=%0d hand=%b hn=%0d lib=%0d fas=%0d go=%0b; required err=%0b stack=%h sn=%0d dn=%0d hand=%b hn=%0d lib=%0d fas=%0d go=%0b",
                   mon_a.err, mon_a.stack, mon_a.stack_n, mon_a.disc_n, mon_a.hand, mon_a.hand_n,
                   mon_a.lib, mon_a.fas, mon_a.over, mon_e.err, mon_e.stack, mon_e.stack_n,
                   mon_e.disc_n, mon_e.hand, mon_e.hand_n, mon_e.lib, mon_e.fas, mon_e.over);
        end
      end
      mon_sum = int'(stack_n) + int'(discard_n) + int'(hand_n) + int'(lib_board) + int'(fas_board);
      n_vec++;
      if (mon_sum != 17) begin
        n_err++;
        $display("FAIL card_count: got %0d cards in total, required 17", mon_sum);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int  op, idx, t;
    bit  ok;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_idx   = 2'd0;
    seed      = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset_state");
    rst = 1'b0;

    // Fresh game, one full turn, then replay of the same seed
    issue(1, 0, 8'hA5);
    issue(2, 0, 8'h00);
    issue(3, 1, 8'h00);
    issue(4, 0, 8'h00);
    issue(1, 0, 8'hA5);

    // Precondition failures interleaved with legal moves
    issue(2, 0, 8'h00);
    issue(4, 0, 8'h00);
    issue(3, 3, 8'h00);
    issue(3, 0, 8'h00);
    issue(2, 0, 8'h00);
    issue(4, 2, 8'h00);
    issue(7, 0, 8'h00);
    issue(6, 0, 8'h00);
    issue(0, 0, 8'h00);
    issue(4, 1, 8'h00);
    issue(6, 0, 8'h00);
    issue(5, 0, 8'h00);

    // Zero seed, then play five turns so the fifth enact forces a reshuffle
    issue(1, 0, 8'h00);
    issue(1, 0, 8'h3C);
    for (int k = 0; k < 5; k++) begin
      issue(2, 0, 8'h00);
      issue(3, $urandom_range(0, 2), 8'h00);
      issue(4, $urandom_range(0, 1), 8'h00);
    end

    // Randomized play
    for (int n = 0; n < 320; n++) begin
      t = $urandom_range(0, 99);
      if (m_over && $urandom_range(0, 2) == 0) op = 1;
      else if (t < 4)  op = 0;
      else if (t < 9)  op = 1;
      else if (t < 35) op = 2;
      else if (t < 60) op = 3;
      else if (t < 86) op = 4;
      else if (t < 91) op = 5;
      else if (t < 96) op = 6;
      else op = 7;
      idx = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
      if (op == 4 && $urandom_range(0, 3) != 0) idx = $urandom_range(0, 1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue(op, idx, 8'($urandom_range(0, 255)));
    end

    // Reset while a shuffle is in flight
    wait_ready(ok);
    if (ok) begin
      cmd_valid = 1'b1;
      cmd_op    = 3'd1;
      cmd_idx   = 2'd0;
      seed      = 8'h5A;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if (cmd_ready !== 1'b0) begin
        n_err++;
        $display("FAIL busy_in_shuffle: cmd_ready=%0b, required 0", cmd_ready);
      end
      rst = 1'b1;
      @(negedge clk);
      check_reset("reset_mid_shuffle");
      rst = 1'b0;
      model_reset();
      repeat (20) @(negedge clk);
      issue(2, 0, 8'h00);
      issue(1, 0, 8'h77);
      issue(2, 0, 8'h00);
    end

    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rsp_timeout: %0d responses outstanding, required 0", exp_q.size());
    end
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
